// File: rtl/exception_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : exception_ctrl
//  Purpose  : Exception / interrupt controller for a simple in-order core.
//             Takes invalid-opcode traps and a synchronized external IRQ,
//             redirects the PC to VECTOR_ADDR, records the return address
//             (ELR) and the cause (ESR), handles ERET and detects double
//             faults.
//  Ports    : clk, reset        - clock, synchronous active-high reset
//             ExtIRQ            - async level interrupt request
//             NotAnInstr, ERet  - decoder flags for the current instruction
//             PC                - address of the current instruction
//             Exc, EVAddr       - PC mux select / vector address
//             ExtIAck           - one-cycle interrupt acknowledge
//             ELR, ESR          - exception link / syndrome registers
//             InHandler, Halt   - handler active / double-fault halt
//  Revision : 1.0 - initial release
// ============================================================================
module exception_ctrl #(
    parameter logic [63:0] VECTOR_ADDR = 64'h0000_0000_0000_00D8,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ExtIRQ,
    input  logic        NotAnInstr,
    input  logic        ERet,
    input  logic [63:0] PC,
    output logic        Exc,
    output logic [63:0] EVAddr,
    output logic        ExtIAck,
    output logic [63:0] ELR,
    output logic [3:0]  ESR,
    output logic        InHandler,
    output logic        Halt
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_ENTER   = 2'd1,
        ST_HANDLER = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    localparam logic [3:0] c_ESR_IRQ   = 4'b0001;
    localparam logic [3:0] c_ESR_UNDEF = 4'b0010;
    localparam logic [3:0] c_ESR_DBL   = 4'b0011;

    state_t                  r_state_q, w_state_d;
    logic [63:0]             r_elr_q,   w_elr_d;
    logic [3:0]              r_esr_q,   w_esr_d;
    logic [SYNC_STAGES-1:0]  r_sync_q,  w_sync_d;
    logic                    w_irq_s;

    // Synchronizer: bit 0 samples the raw request, the top bit feeds the FSM.
    always_comb begin
        w_sync_d = {r_sync_q[SYNC_STAGES-2:0], ExtIRQ};
    end

    assign w_irq_s = r_sync_q[SYNC_STAGES-1];

    always_comb begin
        w_state_d = r_state_q;
        w_elr_d   = r_elr_q;
        w_esr_d   = r_esr_q;
        case (r_state_q)
            ST_RUN: begin
                // Invalid opcode outranks the IRQ; the IRQ level stays
                // pending and is taken after the handler returns.
                if (NotAnInstr) begin
                    w_elr_d   = PC;
                    w_esr_d   = c_ESR_UNDEF;
                    w_state_d = ST_ENTER;
                end else if (w_irq_s) begin
                    w_esr_d   = c_ESR_IRQ;
                    w_state_d = ST_ENTER;
                end
            end
            ST_ENTER: begin
                // For an IRQ the squashed instruction is the one to resume.
                if (r_esr_q == c_ESR_IRQ) begin
                    w_elr_d = PC;
                end
                w_state_d = ST_HANDLER;
            end
            ST_HANDLER: begin
                if (NotAnInstr) begin
                    w_elr_d   = PC;
                    w_esr_d   = c_ESR_DBL;
                    w_state_d = ST_FAULT;
                end else if (ERet) begin
                    w_state_d = ST_RUN;
                end
            end
            ST_FAULT: begin
                w_state_d = ST_FAULT;
            end
            default: begin
                w_state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= ST_RUN;
            r_elr_q   <= 64'd0;
            r_esr_q   <= 4'd0;
            r_sync_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_elr_q   <= w_elr_d;
            r_esr_q   <= w_esr_d;
            r_sync_q  <= w_sync_d;
        end
    end

    // Outputs depend on registers only.
    assign Exc       = (r_state_q == ST_ENTER);
    assign ExtIAck   = (r_state_q == ST_ENTER) && (r_esr_q == c_ESR_IRQ);
    assign InHandler = (r_state_q == ST_HANDLER);
    assign Halt      = (r_state_q == ST_FAULT);
    assign EVAddr    = VECTOR_ADDR;
    assign ELR       = r_elr_q;
    assign ESR       = r_esr_q;

endmodule
`default_nettype wire

// File: tb/tb_exception_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exception_ctrl
//  Purpose  : Self-checking bench for exception_ctrl. Directed scenarios plus
//             randomized traffic; a reference model predicts every cycle's
//             outputs into a queue that a monitor drains and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_exception_ctrl;

    localparam int          SYNC_STAGES = 2;
    localparam logic [63:0] VEC         = 64'h0000_0000_0000_00D8;

    localparam int M_RUN = 0, M_ENTER = 1, M_HANDLER = 2, M_FAULT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ExtIRQ = 1'b0;
    logic        NotAnInstr = 1'b0;
    logic        ERet = 1'b0;
    logic [63:0] PC = 64'd0;
    logic        Exc, ExtIAck, InHandler, Halt;
    logic [63:0] EVAddr, ELR;
    logic [3:0]  ESR;

    exception_ctrl #(
        .VECTOR_ADDR (VEC),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ExtIRQ     (ExtIRQ),
        .NotAnInstr (NotAnInstr),
        .ERet       (ERet),
        .PC         (PC),
        .Exc        (Exc),
        .EVAddr     (EVAddr),
        .ExtIAck    (ExtIAck),
        .ELR        (ELR),
        .ESR        (ESR),
        .InHandler  (InHandler),
        .Halt       (Halt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        exc;
        logic        iack;
        logic        inh;
        logic        halt;
        logic [63:0] elr;
        logic [3:0]  esr;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: mode of the controller, ELR/ESR values and the
    // history of ExtIRQ samples (oldest first = what the FSM currently sees).
    int          m_mode = M_RUN;
    logic [63:0] m_elr  = 64'd0;
    logic [3:0]  m_esr  = 4'd0;
    bit          m_hist[$];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_edge(input bit rst, input bit nai, input bit er,
                                       input bit irq, input logic [63:0] pc);
        bit irq_seen;
        if (rst) begin
            m_mode = M_RUN;
            m_elr  = 64'd0;
            m_esr  = 4'd0;
            m_hist.delete();
            for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back(1'b0);
            return;
        end
        irq_seen = m_hist[0];
        void'(m_hist.pop_front());
        m_hist.push_back(irq);
        if (m_mode == M_RUN) begin
            if (nai) begin
                m_elr = pc; m_esr = 4'b0010; m_mode = M_ENTER;
            end else if (irq_seen) begin
                m_esr = 4'b0001; m_mode = M_ENTER;
            end
        end else if (m_mode == M_ENTER) begin
            if (m_esr == 4'b0001) m_elr = pc;
            m_mode = M_HANDLER;
        end else if (m_mode == M_HANDLER) begin
            if (nai) begin
                m_elr = pc; m_esr = 4'b0011; m_mode = M_FAULT;
            end else if (er) begin
                m_mode = M_RUN;
            end
        end
    endfunction

    // Drive one cycle of inputs (called at a falling edge), predict the
    // result of the coming rising edge, then wait for the next falling edge.
    task automatic step(input bit rst, input bit nai, input bit er,
                        input bit irq, input logic [63:0] pc);
        exp_t e;
        reset = rst; NotAnInstr = nai; ERet = er; ExtIRQ = irq; PC = pc;
        model_edge(rst, nai, er, irq, pc);
        e.exc  = (m_mode == M_ENTER);
        e.iack = (m_mode == M_ENTER) && (m_esr == 4'b0001);
        e.inh  = (m_mode == M_HANDLER);
        e.halt = (m_mode == M_FAULT);
        e.elr  = m_elr;
        e.esr  = m_esr;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: outputs are presented every cycle, compare shortly after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("scoreboard", {Exc, ExtIAck, InHandler, Halt, ELR, ESR}, e);
        end
    end

    initial begin
        int k;
        bit irq_r;
        @(negedge clk);

        // Reset state
        step(1, 0, 0, 0, 64'h0);
        step(1, 0, 0, 0, 64'h0);
        chk("reset_flags", {68'd0, Exc, ExtIAck, InHandler, Halt}, 72'd0);
        chk("reset_elr_esr", {4'd0, ELR, ESR}, 72'd0);
        chk("evaddr", {8'd0, EVAddr}, {8'd0, VEC});

        // Invalid opcode in RUN at 0x40
        step(0, 1, 0, 0, 64'h40);
        chk("undef_exc", {71'd0, Exc}, 72'd1);
        chk("undef_elr", {8'd0, ELR}, {8'd0, 64'h40});
        chk("undef_esr", {68'd0, ESR}, {68'd0, 4'b0010});
        step(0, 0, 0, 0, 64'hD8);
        chk("undef_inh", {70'd0, InHandler, Exc}, 72'd2);
        step(0, 0, 1, 0, 64'hDC);
        chk("eret_to_run", {70'd0, InHandler, Exc}, 72'd0);
        step(0, 0, 1, 0, 64'h100);
        chk("eret_ignored_in_run", {2'd0, Exc, InHandler, ELR, ESR}, {2'd0, 2'b00, 64'h40, 4'b0010});

        // External IRQ: count cycles from first sampling edge to ExtIAck
        k = 99;
        for (int i = 1; i <= 10; i++) begin
            step(0, 0, 0, 1, 64'h1C);
            if (ExtIAck) begin k = i; break; end
        end
        chk("irq_to_ack_cycles", 72'(k + 1), 72'(SYNC_STAGES + 2));
        chk("irq_esr", {68'd0, ESR}, {68'd0, 4'b0001});
        step(0, 0, 0, 1, 64'h1C);
        chk("irq_elr", {8'd0, ELR}, {8'd0, 64'h1C});
        chk("ack_single_pulse", {70'd0, ExtIAck, InHandler}, 72'd1);

        // IRQ held in handler is masked
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 64'hE0 + 64'(i));
            chk("irq_masked", {70'd0, ExtIAck, InHandler}, 72'd1);
        end
        step(0, 0, 1, 1, 64'hF0);
        chk("eret_irq_run", {70'd0, Exc, InHandler}, 72'd0);
        step(0, 0, 0, 1, 64'h20);
        chk("irq_after_eret", {70'd0, Exc, ExtIAck}, 72'd3);
        step(0, 0, 0, 0, 64'h20);
        for (int i = 0; i < SYNC_STAGES + 1; i++) step(0, 0, 0, 0, 64'hE4);
        step(0, 0, 1, 0, 64'hE8);
        step(0, 0, 0, 0, 64'h24);
        chk("idle_run", {70'd0, Exc, InHandler}, 72'd0);

        // Invalid opcode and synchronized IRQ together in RUN
        for (int i = 0; i < SYNC_STAGES; i++) step(0, 0, 0, 1, 64'h7C);
        step(0, 1, 0, 1, 64'h80);
        chk("prio_esr", {68'd0, ESR}, {68'd0, 4'b0010});
        chk("prio_noack", {70'd0, Exc, ExtIAck}, 72'd2);
        step(0, 0, 0, 1, 64'hD8);
        step(0, 0, 1, 1, 64'hDC);
        step(0, 0, 0, 1, 64'h84);
        chk("pending_irq_taken", {66'd0, Exc, ExtIAck, ESR}, {66'd0, 2'b11, 4'b0001});
        step(0, 0, 0, 0, 64'h84);
        for (int i = 0; i < SYNC_STAGES + 1; i++) step(0, 0, 0, 0, 64'hD8);
        step(0, 0, 1, 0, 64'hDC);

        // Double fault (NotAnInstr and ERet together), sticky, then reset
        step(0, 1, 0, 0, 64'h50);
        step(0, 0, 0, 0, 64'hD8);
        step(0, 1, 1, 0, 64'hE0);
        chk("fault_halt", {69'd0, Halt, Exc, InHandler}, 72'd4);
        chk("fault_esr", {68'd0, ESR}, {68'd0, 4'b0011});
        chk("fault_elr", {8'd0, ELR}, {8'd0, 64'hE0});
        for (int i = 0; i < 6; i++) begin
            step(0, i[0], i[1], 1, 64'(i * 4));
            chk("fault_sticky", {68'd0, Halt, Exc, ExtIAck, ESR == 4'b0011}, 72'h9);
        end
        step(1, 0, 0, 0, 64'h0);
        chk("fault_reset", {68'd0, Exc, ExtIAck, InHandler, Halt}, 72'd0);

        // Reset in the middle of an IRQ entry
        k = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 1, 64'h60);
            if (Exc) begin k = 1; break; end
        end
        chk("reach_enter", 72'(k), 72'd1);
        step(1, 0, 0, 0, 64'h64);
        chk("enter_reset", {2'd0, Exc, ExtIAck, ELR, ESR}, 72'd0);
        for (int i = 0; i < SYNC_STAGES + 2; i++) begin
            step(0, 0, 0, 0, 64'h68);
            chk("no_irq_after_reset", {71'd0, Exc}, 72'd0);
        end

        // Randomized traffic
        irq_r = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(15) == 0) irq_r = ~irq_r;
            step($urandom_range(63) == 0, $urandom_range(7) == 0,
                 $urandom_range(3) == 0, irq_r, {$urandom, $urandom});
        end

        step(0, 0, 0, 0, 64'h0);
        chk("scoreboard_drained", 72'(sb_q.size()), 72'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
